// File: rtl/cms_pix_28_fw_pkg.sv
// Shared types and constants for the FW configuration-chain sequencer family.
package cms_pix_28_fw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOW,
    ST_HIGH,
    ST_RSTALL,
    ST_LOAD,
    ST_FIN
  } cfg_state_e;

  // Smallest half-period that still lets the synchronized return data settle before capture.
  localparam int unsigned MIN_CAPTURE_HALF = 3;
  // fw_config_load lasts this many half-periods.
  localparam int unsigned LOAD_WIDTH_FACTOR = 2;

endpackage

// File: rtl/cms_pix_28_fw_sync2.sv
// Generic two-flop synchronizer for asynchronous inputs coming back from the DUT.
module cms_pix_28_fw_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops; the first may go metastable, the second resolves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/cms_pix_28_fw_cfg_shift_ctrl.sv
// Configuration shift-chain sequencer: streams words MSB-first onto fw_config_in,
// captures fw_config_out into left-aligned read words, and strobes fw_config_load.
module cms_pix_28_fw_cfg_shift_ctrl
  import cms_pix_28_fw_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              fw_clk,
  input  logic              fw_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_bits,
  input  logic [DIV_W-1:0]  clk_half_div,
  input  logic              load_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              fw_config_clk,
  output logic              fw_config_in,
  output logic              fw_config_load,
  input  logic              fw_config_out
);

  localparam int unsigned WC_W = $clog2(WORD_W) + 1;
  localparam int unsigned PH_W = DIV_W + 2;
  localparam logic [WC_W-1:0] WORD_BITS = WC_W'(WORD_W);

  cfg_state_e        state_q, state_d;
  logic [CNT_W-1:0]  num_bits_q, num_bits_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  half_q, half_d;
  logic              load_en_q, load_en_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] cap_q, cap_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic [WC_W-1:0]   wr_left_q, wr_left_d;
  logic [WC_W-1:0]   cap_cnt_q, cap_cnt_d;

  logic              cfg_out_s;
  logic [PH_W-1:0]   half_ext;
  logic [PH_W-1:0]   load_len;
  logic              phase_last;
  logic              load_last;
  logic [WORD_W-1:0] cap_shift;
  logic [WORD_W-1:0] cap_aligned;
  logic [WC_W-1:0]   cap_cnt_inc;
  logic [WC_W-1:0]   wr_left_dec;
  logic [CNT_W-1:0]  bit_cnt_inc;
  logic              rd_blocked;

  cms_pix_28_fw_sync2 #(.WIDTH(1)) u_sync_cfg_out (
    .clk   (fw_clk),
    .rst_n (fw_rst_n),
    .d     (fw_config_out),
    .q     (cfg_out_s)
  );

  assign half_ext    = PH_W'(half_q);
  assign load_len    = PH_W'(LOAD_WIDTH_FACTOR) * half_ext;
  assign phase_last  = (phase_q == half_ext - PH_W'(1));
  assign load_last   = (phase_q == load_len - PH_W'(1));
  assign cap_shift   = {cap_q[WORD_W-2:0], cfg_out_s};
  assign cap_cnt_inc = cap_cnt_q + WC_W'(1);
  // A partial final word is pushed up so its first captured bit lands in the MSB.
  assign cap_aligned = cap_shift << (WORD_BITS - cap_cnt_inc);
  assign wr_left_dec = wr_left_q - WC_W'(1);
  assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);
  assign rd_blocked  = rd_valid_q && !rd_ready;

  // Where to go once any pending capture word has been pushed.
  function automatic cfg_state_e after_push(input logic at_end, input logic word_empty,
                                            input logic ld);
    if (at_end)          return ld ? ST_LOAD : ST_FIN;
    else if (word_empty) return ST_FETCH;
    else                 return ST_LOW;
  endfunction

  // Next-state, datapath and handshake logic; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    num_bits_d = num_bits_q;
    bit_cnt_d  = bit_cnt_q;
    half_d     = half_q;
    load_en_d  = load_en_q;
    phase_d    = phase_q;
    shift_d    = shift_q;
    cap_d      = cap_q;
    cap_cnt_d  = cap_cnt_q;
    wr_left_d  = wr_left_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q && !rd_ready;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_bits_d = num_bits;
          half_d     = (clk_half_div == '0) ? DIV_W'(1) : clk_half_div;
          load_en_d  = load_en;
          bit_cnt_d  = '0;
          cap_d      = '0;
          cap_cnt_d  = '0;
          phase_d    = '0;
          if (num_bits == '0) state_d = load_en ? ST_LOAD : ST_FIN;
          else                state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (wr_valid) begin
          shift_d   = wr_data;
          wr_left_d = WORD_BITS;
          phase_d   = '0;
          state_d   = ST_LOW;
        end
      end
      ST_LOW: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = ST_HIGH;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_HIGH: begin
        if (!phase_last) begin
          phase_d = phase_q + PH_W'(1);
        end else begin
          phase_d   = '0;
          bit_cnt_d = bit_cnt_inc;
          shift_d   = {shift_q[WORD_W-2:0], 1'b0};
          wr_left_d = wr_left_dec;
          if ((cap_cnt_inc == WORD_BITS) || (bit_cnt_inc == num_bits_q)) begin
            cap_cnt_d = '0;
            if (rd_blocked) begin
              // Park the finished word in cap_q until the consumer drains rd_data.
              cap_d   = cap_aligned;
              state_d = ST_RSTALL;
            end else begin
              cap_d      = '0;
              rd_data_d  = cap_aligned;
              rd_valid_d = 1'b1;
              state_d    = after_push(bit_cnt_inc == num_bits_q, wr_left_dec == '0, load_en_q);
            end
          end else begin
            cap_d     = cap_shift;
            cap_cnt_d = cap_cnt_inc;
            state_d   = after_push(1'b0, wr_left_dec == '0, load_en_q);
          end
        end
      end
      ST_RSTALL: begin
        if (!rd_blocked) begin
          rd_data_d  = cap_q;
          rd_valid_d = 1'b1;
          cap_d      = '0;
          state_d    = after_push(bit_cnt_q == num_bits_q, wr_left_q == '0, load_en_q);
        end
      end
      ST_LOAD: begin
        if (load_last) begin
          phase_d = '0;
          state_d = ST_FIN;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      ST_FIN: begin
        shift_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      rd_valid_d = 1'b0;
      phase_d    = '0;
      shift_d    = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      state_q    <= ST_IDLE;
      num_bits_q <= '0;
      bit_cnt_q  <= '0;
      half_q     <= '0;
      load_en_q  <= 1'b0;
      phase_q    <= '0;
      shift_q    <= '0;
      cap_q      <= '0;
      cap_cnt_q  <= '0;
      wr_left_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_bits_q <= num_bits_d;
      bit_cnt_q  <= bit_cnt_d;
      half_q     <= half_d;
      load_en_q  <= load_en_d;
      phase_q    <= phase_d;
      shift_q    <= shift_d;
      cap_q      <= cap_d;
      cap_cnt_q  <= cap_cnt_d;
      wr_left_q  <= wr_left_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign wr_ready       = (state_q == ST_FETCH);
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_FIN);
  assign fw_config_clk  = (state_q == ST_HIGH);
  assign fw_config_load = (state_q == ST_LOAD);
  assign fw_config_in   = shift_q[WORD_W-1];
  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign bit_cnt        = bit_cnt_q;

endmodule

// File: tb/tb_cms_pix_28_fw_cfg_shift_ctrl.sv
// Scoreboard bench for the configuration shift-chain sequencer with DUT loopback.
module tb_cms_pix_28_fw_cfg_shift_ctrl;
  import cms_pix_28_fw_pkg::*;

  localparam int TO = 5000;

  logic        fw_clk = 1'b0;
  logic        fw_rst_n;
  logic        start, abort, load_en, wr_valid, rd_ready;
  logic [15:0] num_bits;
  logic [7:0]  clk_half_div;
  logic [31:0] wr_data, rd_data;
  logic        wr_ready, rd_valid, busy, done;
  logic [15:0] bit_cnt;
  logic        fw_config_clk, fw_config_in, fw_config_load, fw_config_out;

  int          rd_mode = 1;   // 0 = hold low, 1 = always ready, 2 = random
  logic        rd_rnd = 1'b1;
  bit          rd_chk_en = 1'b1;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, edge_cnt = 0, load_cnt = 0, done_cnt = 0, fetch_clk_viol = 0;
  bit          prev_clk = 1'b0;
  bit          exp_bits[$];
  logic [31:0] exp_rd[$];
  logic [31:0] op_words[$];
  int          edge_cyc[$];
  int          hs_cyc[$];

  assign rd_ready      = (rd_mode == 2) ? rd_rnd : (rd_mode == 1);
  assign fw_config_out = fw_config_in;   // chain loopback

  cms_pix_28_fw_cfg_shift_ctrl #(.WORD_W(32), .CNT_W(16), .DIV_W(8)) dut (
    .fw_clk(fw_clk), .fw_rst_n(fw_rst_n), .start(start), .abort(abort),
    .num_bits(num_bits), .clk_half_div(clk_half_div), .load_en(load_en),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .bit_cnt(bit_cnt),
    .fw_config_clk(fw_config_clk), .fw_config_in(fw_config_in),
    .fw_config_load(fw_config_load), .fw_config_out(fw_config_out)
  );

  initial forever #5 fw_clk = ~fw_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  initial forever begin
    @(posedge fw_clk);
    #1 rd_rnd = 1'($urandom_range(0, 1));
  end

  // Monitor: edge/load/done bookkeeping plus scoreboard pops for chain bits and read words.
  initial forever begin
    @(negedge fw_clk);
    cyc++;
    if (fw_config_load) load_cnt++;
    if (done) done_cnt++;
    if (wr_ready && fw_config_clk) fetch_clk_viol++;
    if (wr_valid && wr_ready) hs_cyc.push_back(cyc);
    if (fw_config_clk && !prev_clk) begin
      edge_cnt++;
      edge_cyc.push_back(cyc);
      if (exp_bits.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL cfg_in_extra: got edge with data %0b expected no edge", fw_config_in);
      end else chk("cfg_in_bit", 64'(fw_config_in), 64'(exp_bits.pop_front()));
    end
    prev_clk = fw_config_clk;
    if (rd_valid && rd_ready && rd_chk_en) begin
      if (exp_rd.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_extra: got 0x%0h expected no word", rd_data);
      end else chk("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
    end
  end

  // Reference model: bits MSB-first across words; read words are the same bits, left-aligned.
  task automatic build_expect(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      logic [31:0] w;
      w = op_words[i / 32];
      exp_bits.push_back(w[31 - (i % 32)]);
    end
    if (rd_chk_en) begin
      for (int j = 0; j * 32 < nbits; j++) begin
        int nb;
        logic [31:0] mask;
        nb = nbits - 32 * j;
        if (nb >= 32) mask = '1;
        else          mask = ~(32'hFFFF_FFFF >> nb);
        exp_rd.push_back(op_words[j] & mask);
      end
    end
  endtask

  task automatic check_idle_outputs();
    chk("idle_busy", 64'(busy), 0);
    chk("idle_done", 64'(done), 0);
    chk("idle_wr_ready", 64'(wr_ready), 0);
    chk("idle_rd_valid", 64'(rd_valid), 0);
    chk("idle_cfg_clk", 64'(fw_config_clk), 0);
    chk("idle_cfg_in", 64'(fw_config_in), 0);
    chk("idle_cfg_load", 64'(fw_config_load), 0);
    chk("idle_bit_cnt", 64'(bit_cnt), 0);
    chk("idle_rd_data", 64'(rd_data), 0);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    repeat (gap) @(posedge fw_clk);
    #1; wr_data = w; wr_valid = 1'b1;
    n = 0;
    do begin @(negedge fw_clk); n++; end while (!wr_ready && n < TO);
    chk("wr_handshake", 64'(wr_ready), 1);
    @(posedge fw_clk);
    #1; wr_valid = 1'b0; wr_data = '0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < TO) begin @(negedge fw_clk); n++; end
    chk("done_seen", 64'(done), 1);
  endtask

  task automatic rd_stall_seq(input int nbits, input int heff, input int e0);
    int n, bad, d1;
    n = 0;
    while ((edge_cnt - e0) < nbits && n < TO) begin @(negedge fw_clk); n++; end
    repeat (2 * heff + 2) @(negedge fw_clk);
    bad = 0; d1 = done_cnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge fw_clk);
      if (fw_config_clk || !busy || !rd_valid) bad++;
    end
    chk("stall_clk_low", 64'(bad), 0);
    chk("stall_no_done", 64'(done_cnt - d1), 0);
    @(posedge fw_clk);
    #1 rd_mode = 1;
  endtask

  task automatic run_op(input int nbits, input int h, input bit ld, input int gap,
                        input bit rd_bp, input bit restart);
    int heff, e0, l0, d0;
    heff = (h == 0) ? 1 : h;
    rd_chk_en = (heff >= int'(MIN_CAPTURE_HALF));
    build_expect(nbits);
    edge_cyc.delete(); hs_cyc.delete();
    e0 = edge_cnt; l0 = load_cnt; d0 = done_cnt;
    if (rd_bp) rd_mode = 0;
    @(posedge fw_clk);
    #1; start = 1'b1; num_bits = 16'(nbits); clk_half_div = 8'(h); load_en = ld;
    @(posedge fw_clk);
    #1 start = 1'b0;
    fork
      begin foreach (op_words[j]) send_word(op_words[j], gap); end
      begin if (rd_bp) rd_stall_seq(nbits, heff, e0); end
      begin
        if (restart) begin
          repeat (15) @(posedge fw_clk);
          #1; start = 1'b1; num_bits = 16'd5; load_en = !ld;
          @(posedge fw_clk);
          #1 start = 1'b0;
        end
      end
    join
    wait_done();
    repeat (4) @(negedge fw_clk);
    chk("edge_count", 64'(edge_cnt - e0), 64'(nbits));
    chk("load_cycles", 64'(load_cnt - l0), ld ? 64'(2 * heff) : 0);
    chk("done_once", 64'(done_cnt - d0), 1);
    chk("bit_cnt", 64'(bit_cnt), 64'(nbits));
    chk("bits_pending", 64'(exp_bits.size()), 0);
    if (rd_chk_en) chk("rd_pending", 64'(exp_rd.size()), 0);
    if (nbits >= 1) chk("first_edge_latency", 64'(edge_cyc[0] - hs_cyc[0]), 64'(1 + heff));
    if (nbits >= 2) chk("bit_period", 64'(edge_cyc[1] - edge_cyc[0]), 64'(2 * heff));
    exp_bits.delete(); exp_rd.delete();
  endtask

  task automatic rand_words(input int nbits);
    op_words.delete();
    for (int j = 0; j * 32 < nbits; j++) op_words.push_back($urandom);
  endtask

  initial begin
    int e0, d0, n;
    fw_rst_n = 1'b0; start = 1'b0; abort = 1'b0; load_en = 1'b0; wr_valid = 1'b0;
    num_bits = '0; clk_half_div = '0; wr_data = '0;
    repeat (3) @(negedge fw_clk);
    check_idle_outputs();
    #2 fw_rst_n = 1'b1;
    repeat (2) @(negedge fw_clk);
    check_idle_outputs();

    // Basic single partial word with load.
    op_words.delete(); op_words.push_back(32'hA500_0000);
    run_op(8, 4, 1'b1, 0, 1'b0, 1'b0);
    chk("basic_rd_word", 64'(rd_data), 64'h0000_0000_A500_0000);

    // Two words, slow producer, consumer backpressure on the final word.
    rand_words(40);
    run_op(40, 3, 1'b0, 10, 1'b1, 1'b0);

    // Zero-length chain: load only.
    op_words.delete();
    run_op(0, 2, 1'b1, 0, 1'b0, 1'b0);

    // Abort in the HIGH phase of bit 5, with a start in the same cycle.
    rand_words(16);
    rd_chk_en = 1'b0;
    build_expect(16);
    e0 = edge_cnt; d0 = done_cnt;
    @(posedge fw_clk);
    #1; start = 1'b1; num_bits = 16'd16; clk_half_div = 8'd4; load_en = 1'b1;
    @(posedge fw_clk);
    #1 start = 1'b0;
    send_word(op_words[0], 0);
    n = 0;
    while ((edge_cnt - e0) < 5 && n < TO) begin @(negedge fw_clk); n++; end
    abort = 1'b1; start = 1'b1;
    @(posedge fw_clk);
    #1; abort = 1'b0; start = 1'b0;
    @(negedge fw_clk);
    chk("abort_cfg_clk", 64'(fw_config_clk), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_rd_valid", 64'(rd_valid), 0);
    chk("abort_wr_ready", 64'(wr_ready), 0);
    repeat (20) @(negedge fw_clk);
    chk("abort_no_done", 64'(done_cnt - d0), 0);
    chk("abort_edges", 64'(edge_cnt - e0), 5);
    chk("abort_bits_left", 64'(exp_bits.size()), 11);
    exp_bits.delete();

    // Start and abort together while idle: abort wins.
    @(posedge fw_clk);
    #1; start = 1'b1; abort = 1'b1; num_bits = 16'd8;
    @(posedge fw_clk);
    #1; start = 1'b0; abort = 1'b0;
    @(negedge fw_clk);
    chk("start_abort_busy", 64'(busy), 0);

    // Randomized operations with random consumer readiness; one gets a start while busy.
    rd_mode = 2;
    for (int r = 0; r < 5; r++) begin
      int nb;
      nb = (r == 1) ? int'($urandom_range(20, 70)) : int'($urandom_range(1, 70));
      rand_words(nb);
      run_op(nb, int'($urandom_range(3, 5)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'b0, r == 1);
    end
    rd_mode = 1;

    // Half-period of zero behaves as one.
    rand_words(4);
    run_op(4, 0, 1'b1, 0, 1'b0, 1'b0);

    // Reset asserted in the middle of LOAD.
    d0 = done_cnt;
    @(posedge fw_clk);
    #1; start = 1'b1; num_bits = '0; load_en = 1'b1; clk_half_div = 8'd10;
    @(posedge fw_clk);
    #1 start = 1'b0;
    n = 0;
    while (!fw_config_load && n < TO) begin @(negedge fw_clk); n++; end
    chk("load_started", 64'(fw_config_load), 1);
    repeat (3) @(negedge fw_clk);
    #2 fw_rst_n = 1'b0;
    #1 check_idle_outputs();
    @(negedge fw_clk);
    #2 fw_rst_n = 1'b1;
    repeat (5) @(negedge fw_clk);
    chk("post_reset_busy", 64'(busy), 0);
    chk("post_reset_no_done", 64'(done_cnt - d0), 0);

    // Normal operation after reset.
    rand_words(33);
    run_op(33, 3, 1'b1, 1, 1'b0, 1'b0);

    chk("clk_low_in_fetch", 64'(fetch_clk_viol), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cms_pix_28_fw_cfg_shift_ctrl.md
Name: cms_pix_28_fw_cfg_shift_ctrl

Overview:
- Sequencer for the DUT configuration shift chain: bit-bangs fw_config_clk/fw_config_in, captures fw_config_out, and pulses fw_config_load at the end.
- Sits between the FW op-code decoder (w/r_cfg_array word streams) and the fw_config_* DUT pins.
- Word streams use valid/ready handshakes; the block stalls the chain clock rather than dropping bits.

Parameters:
WORD_W, 32, data word width (bits shifted MSB-first)
CNT_W, 16, width of bit counter (max chain length 2^CNT_W-1)
DIV_W, 8, width of half-period divider

Ports:
fw_clk  in  1  FW clock
fw_rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle start pulse, ignored while busy
abort  in  1  one-cycle abort, highest priority after reset
num_bits  in  CNT_W  bits to shift, sampled at start
clk_half_div  in  DIV_W  config_clk half-period H in fw_clk cycles, 0 treated as 1, sampled at start
load_en  in  1  issue fw_config_load after last bit, sampled at start
wr_data  in  WORD_W  next word to shift in
wr_valid  in  1  wr_data valid
wr_ready  out  1  word accepted when wr_valid&wr_ready
rd_data  out  WORD_W  captured word
rd_valid  out  1  rd_data valid, held until rd_ready
rd_ready  in  1  consumer accepts rd_data
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
bit_cnt  out  CNT_W  bits shifted so far
fw_config_clk  out  1  chain clock to DUT
fw_config_in  out  1  chain serial data to DUT
fw_config_load  out  1  chain load strobe to DUT
fw_config_out  in  1  chain serial data from DUT (asynchronous)

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Applies asynchronously mid-operation.
- fw_config_out passes through a 2-flop synchronizer. Correct capture requires H>=3; write-only use allows H>=1.
- States: IDLE, FETCH, LOW, HIGH, RSTALL, LOAD, FIN.
- IDLE: on start, latch parameters and clear bit_cnt.
  - num_bits==0: go to LOAD if load_en, else FIN.
  - Otherwise go to FETCH.
- FETCH: wr_ready=1, fw_config_clk=0. On handshake, load the shift register and go to LOW; fw_config_in = wr_data[WORD_W-1] in the following cycle.
- LOW: fw_config_clk=0 for H cycles; fw_config_in is stable for the whole phase. Then go to HIGH.
- HIGH: fw_config_clk=1 for H cycles.
  - On the last HIGH cycle, shift the synchronized fw_config_out into capture reg bit 0 (shift left) and increment bit_cnt.
  - Then go to the next decision.
- Next decision, in priority order:
  - Capture word complete (32 bits) or last bit of a partial word: if rd_valid&!rd_ready, go to RSTALL (clk held low). Otherwise push to rd_data, rd_valid=1.
  - bit_cnt==num_bits: go to LOAD if load_en, else FIN.
  - Word exhausted: go to FETCH.
  - Otherwise: go to LOW with the next shift bit.
- Partial final word: rd_data is left-aligned, so the first captured bit of the word sits at bit WORD_W-1; unused LSBs are 0. Unused LSBs of the final wr word are ignored.
- RSTALL: wait for rd_ready, then push and continue per the decision above.
- LOAD: fw_config_load=1 for 2H cycles, fw_config_clk=0, then go to FIN.
- FIN: done=1 for one cycle, then IDLE. rd_valid may remain high.
- rd_valid clears on rd_valid&rd_ready unless a new push occurs in the same cycle, in which case it stays 1 with new data.
- abort: next cycle state=IDLE; fw_config_clk, fw_config_load, wr_ready and rd_valid go to 0; no done pulse.
- Simultaneous start and abort: abort wins.
- Latency: with a wr handshake at cycle k, fw_config_in is valid at k+1, the first rising fw_config_clk edge is at k+1+H, and each bit takes 2H cycles.

Decomposition:
- Package cms_pix_28_fw_pkg:
  - State enum type.
  - Localparams for minimum capture H (3) and load width factor (2).
- Sub-module cms_pix_28_fw_sync2: generic 2-flop synchronizer, reused for fw_scan_out and dnn outputs later.

Test Plan:
- Basic: num_bits=8, H=4, wr_data=0xA5000000, DUT loopback (config_out = delayed config_in) →
  - fw_config_in sequence 1,0,1,0,0,1,0,1 on rising edges.
  - rd_data=0xA5000000, bit_cnt=8.
  - load high 8 cycles, done once.
- Multi-word with backpressure: num_bits=40, wr_valid delayed 10 cycles between words, rd_ready low 50 cycles →
  - fw_config_clk stays 0 during both stalls.
  - Exactly 40 rising edges.
  - Two rd words, the second left-aligned in bits 31:24.
- num_bits=0, load_en=1, H=2 → no config_clk edges, load high 4 cycles, done.
- abort during HIGH phase of bit 5 → next cycle fw_config_clk=0, busy=0, rd_valid=0, no done; a subsequent start runs normally.
- start while busy → ignored. Reset asserted mid-LOAD → all outputs 0 immediately.
- H=0 → behaves as H=1 (2-cycle bit period).
